// File: rtl/ks_bist_ctrl_if.sv
// Test-mode bus between the BIST controller and the adder under test.
// The master side is the controller; the slave side is the adder harness or host.
interface ks_bist_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             cin;
  logic [4:0]       sum_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [8:0]       first_fail_vec;
  logic [4:0]       first_fail_sum;

  modport master (
    input  start, sum_in,
    output a, b, cin, busy, done, pass, err_count, first_fail_vec, first_fail_sum
  );

  modport slave (
    output start, sum_in,
    input  a, b, cin, busy, done, pass, err_count, first_fail_vec, first_fail_sum
  );
endinterface

// File: rtl/ks_bist_ctrl.sv
// BIST engine for the 4-bit Kogge-Stone adder: presents vectors, checks the
// returned sum one cycle later against a+b+cin, and keeps pass/fail results.
module ks_bist_ctrl #(
  parameter int         MODE        = 0,
  parameter int         NUM_VECTORS = 512,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter int         CNT_W       = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  ks_bist_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [9:0]       idx_q, idx_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [8:0]       vec_q, vec_d;      // presented {cin,a,b}
  logic             vld_q, vld_d;      // compare stage holds a sample
  logic [4:0]       gold_q, gold_d;
  logic [4:0]       samp_q, samp_d;
  logic [8:0]       cvec_q, cvec_d;    // vector belonging to the sample
  logic [CNT_W-1:0] err_q, err_d;
  logic [8:0]       ffv_q, ffv_d;
  logic [4:0]       ffs_q, ffs_d;
  logic             mismatch;
  logic [4:0]       cur_gold;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  function automatic logic [7:0] lfsr_step(logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [8:0] vec_of(logic [8:0] idx, logic [7:0] s);
    return (MODE == 1) ? {s[7] ^ s[0], s} : idx;
  endfunction

  assign cur_gold = 5'(vec_q[7:4]) + 5'(vec_q[3:0]) + 5'(vec_q[8]);
  assign mismatch = vld_q && (samp_q != gold_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    vld_d   = 1'b0;
    gold_d  = gold_q;
    samp_d  = samp_q;
    cvec_d  = cvec_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffs_d   = ffs_q;

    if (mismatch) begin
      if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
      if (err_q == '0) begin
        ffv_d = cvec_q;
        ffs_d = samp_q;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          lfsr_d  = LFSR_SEED;
          vec_d   = vec_of(9'd0, LFSR_SEED);
          err_d   = '0;
          ffv_d   = '0;
          ffs_d   = '0;
        end
      end
      RUN: begin
        vld_d  = 1'b1;
        gold_d = cur_gold;
        samp_d = bus.sum_in;
        cvec_d = vec_q;
        // last vector stays on the bus while its sample drains
        if (idx_q == 10'(NUM_VECTORS - 1)) begin
          state_d = DRAIN;
        end else begin
          idx_d  = idx_q + 10'd1;
          lfsr_d = lfsr_step(lfsr_q);
          vec_d  = vec_of(idx_d[8:0], lfsr_d);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      gold_q  <= '0;
      samp_q  <= '0;
      cvec_q  <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffs_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
      gold_q  <= gold_d;
      samp_q  <= samp_d;
      cvec_q  <= cvec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffs_q   <= ffs_d;
    end
  end

  assign bus.a              = vec_q[7:4];
  assign bus.b              = vec_q[3:0];
  assign bus.cin            = vec_q[8];
  assign bus.busy           = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = (state_q == DONE) && (err_q == '0);
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.first_fail_sum = ffs_q;

endmodule

// File: tb/tb_ks_bist_ctrl.sv
// Bench for ks_bist_ctrl: three configurations driven by a faultable adder,
// checked each cycle against a vector-list / run-result model.
module tb_ks_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [2:0] start;
  int         fault [3];
  logic [4:0] badmask [512];
  bit         chk_on;

  int         ncfg   [3] = '{512, 4, 512};
  int         satcfg [3] = '{1023, 1023, 255};
  int         modecfg[3] = '{0, 1, 0};

  int npass = 0;
  int ntot  = 0;

  ks_bist_ctrl_if #(.CNT_W(10)) bus0();
  ks_bist_ctrl_if #(.CNT_W(10)) bus1();
  ks_bist_ctrl_if #(.CNT_W(8))  bus2();

  ks_bist_ctrl #(.MODE(0), .NUM_VECTORS(512), .LFSR_SEED(8'hA5), .CNT_W(10))
    u0 (.clk(clk), .rst_n(rst_n[0]), .bus(bus0));
  ks_bist_ctrl #(.MODE(1), .NUM_VECTORS(4), .LFSR_SEED(8'hA5), .CNT_W(10))
    u1 (.clk(clk), .rst_n(rst_n[1]), .bus(bus1));
  ks_bist_ctrl #(.MODE(0), .NUM_VECTORS(512), .LFSR_SEED(8'hA5), .CNT_W(8))
    u2 (.clk(clk), .rst_n(rst_n[2]), .bus(bus2));

  // adder under test: ideal, sum[4] stuck-at-0, sum[0] inverted, random table
  function automatic logic [4:0] adder(logic [8:0] v, int f, logic [4:0] m);
    logic [4:0] s;
    s = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
    case (f)
      1:       s[4] = 1'b0;
      2:       s[0] = ~s[0];
      3:       s = s ^ m;
      default: ;
    endcase
    return s;
  endfunction

  logic [8:0] ovec [3];
  logic       obusy[3], odone[3], opass[3];
  int         oerr [3];
  logic [8:0] offv [3];
  logic [4:0] offs [3];

  assign bus0.start = start[0];
  assign bus1.start = start[1];
  assign bus2.start = start[2];
  assign ovec[0] = {bus0.cin, bus0.a, bus0.b};
  assign ovec[1] = {bus1.cin, bus1.a, bus1.b};
  assign ovec[2] = {bus2.cin, bus2.a, bus2.b};
  assign bus0.sum_in = adder(ovec[0], fault[0], badmask[ovec[0]]);
  assign bus1.sum_in = adder(ovec[1], fault[1], badmask[ovec[1]]);
  assign bus2.sum_in = adder(ovec[2], fault[2], badmask[ovec[2]]);
  assign obusy[0] = bus0.busy;  assign odone[0] = bus0.done;  assign opass[0] = bus0.pass;
  assign obusy[1] = bus1.busy;  assign odone[1] = bus1.done;  assign opass[1] = bus1.pass;
  assign obusy[2] = bus2.busy;  assign odone[2] = bus2.done;  assign opass[2] = bus2.pass;
  assign oerr[0] = int'(bus0.err_count);
  assign oerr[1] = int'(bus1.err_count);
  assign oerr[2] = int'(bus2.err_count);
  assign offv[0] = bus0.first_fail_vec;  assign offs[0] = bus0.first_fail_sum;
  assign offv[1] = bus1.first_fail_vec;  assign offs[1] = bus1.first_fail_sum;
  assign offv[2] = bus2.first_fail_vec;  assign offs[2] = bus2.first_fail_sum;

  task automatic chk(string name, int k, longint act, longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h", name, k, $time, act, exp);
  endtask

  // ---------------- model ----------------
  logic [8:0] vecs [3][512];
  bit         act  [3];
  int         t    [3];
  int         exp_err[3];
  logic [8:0] exp_ffv[3];
  logic [4:0] exp_ffs[3];
  int         busy_cnt[3];

  function automatic void build_vecs();
    logic [7:0] s;
    for (int k = 0; k < 3; k++) begin
      s = 8'hA5;
      for (int i = 0; i < 512; i++) begin
        if (modecfg[k] == 1) begin
          vecs[k][i] = {s[7] ^ s[0], s};
          s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end else begin
          vecs[k][i] = 9'(i);
        end
      end
    end
  endfunction

  function automatic void predict(int k);
    int         e;
    logic [8:0] v;
    logic [4:0] good, got;
    e = 0;
    exp_ffv[k] = '0;
    exp_ffs[k] = '0;
    for (int i = 0; i < ncfg[k]; i++) begin
      v    = vecs[k][i];
      good = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
      got  = adder(v, fault[k], badmask[v]);
      if (got != good) begin
        if (e == 0) begin
          exp_ffv[k] = v;
          exp_ffs[k] = got;
        end
        e++;
      end
    end
    exp_err[k] = (e > satcfg[k]) ? satcfg[k] : e;
  endfunction

  // run timeline: t = cycles since the accepted start edge; busy for t<=N, done after
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        act[k] = 1'b0;
        t[k] = 0;
        exp_err[k] = 0;
        exp_ffv[k] = '0;
        exp_ffs[k] = '0;
      end else if (start[k] && (!act[k] || t[k] > ncfg[k])) begin
        act[k] = 1'b1;
        t[k] = 0;
        predict(k);
      end else if (act[k]) begin
        t[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        if (obusy[k]) busy_cnt[k]++;
        if (!act[k]) begin
          chk("idle_vec", k, ovec[k], 0);
          chk("idle_busy", k, obusy[k], 0);
          chk("idle_done", k, odone[k], 0);
          chk("idle_pass", k, opass[k], 0);
          chk("idle_err", k, oerr[k], 0);
          chk("idle_ffv", k, offv[k], 0);
          chk("idle_ffs", k, offs[k], 0);
        end else if (t[k] <= ncfg[k]) begin
          chk("run_vec", k, ovec[k], vecs[k][(t[k] < ncfg[k]) ? t[k] : ncfg[k] - 1]);
          chk("run_busy", k, obusy[k], 1);
          chk("run_done", k, odone[k], 0);
          chk("run_pass", k, opass[k], 0);
        end else begin
          chk("done_vec", k, ovec[k], vecs[k][ncfg[k] - 1]);
          chk("done_busy", k, obusy[k], 0);
          chk("done_done", k, odone[k], 1);
          chk("done_pass", k, opass[k], (exp_err[k] == 0) ? 1 : 0);
          chk("done_err", k, oerr[k], exp_err[k]);
          chk("done_ffv", k, offv[k], exp_ffv[k]);
          chk("done_ffs", k, offs[k], exp_ffs[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int k);
    int n;
    n = 0;
    while (!odone[k] && n < 1200) begin
      cyc(1);
      n++;
    end
    if (!odone[k]) begin
      ntot++;
      $display("FAIL done_timeout[u%0d]: done still low after %0d cycles", k, n);
    end
  endtask

  task automatic run(int k, int f, int plen);
    fault[k] = f;
    busy_cnt[k] = 0;
    start[k] = 1'b1;
    cyc(plen);
    start[k] = 1'b0;
    wait_done(k);
  endtask

  initial begin
    int k, f, plen;
    start  = '0;
    rst_n  = '0;
    chk_on = 1'b0;
    for (int i = 0; i < 3; i++) fault[i] = 0;
    for (int i = 0; i < 512; i++) badmask[i] = '0;
    build_vecs();
    cyc(2);
    chk_on = 1'b1;
    rst_n  = '1;
    chk("rst_vec", 0, ovec[0], 0);
    chk("rst_err", 0, oerr[0], 0);
    chk("model_lfsr_v0", 1, vecs[1][0], 9'h0A5);

    // ideal adder, exhaustive
    run(0, 0, 1);
    chk("ideal_pass", 0, opass[0], 1);
    chk("ideal_err", 0, oerr[0], 0);
    chk("ideal_ffv", 0, offv[0], 0);
    chk("ideal_busy_cycles", 0, busy_cnt[0], 513);

    // sum[4] stuck-at-0
    run(0, 1, 1);
    chk("stuck_model_err", 0, exp_err[0], 256);
    chk("stuck_err", 0, oerr[0], 256);
    chk("stuck_pass", 0, opass[0], 0);
    chk("stuck_ffv", 0, offv[0], 9'h01F);
    chk("stuck_ffs", 0, offs[0], 5'b00000);

    // sum[0] inverted, 8-bit counter saturates
    run(2, 2, 1);
    chk("sat_err", 2, oerr[2], 255);
    chk("sat_ffv", 2, offv[2], 0);
    chk("sat_ffs", 2, offs[2], 5'b00001);

    // reset 100 cycles into a run
    fault[0] = 0;
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    cyc(100);
    rst_n[0] = 1'b0;
    cyc(1);
    rst_n[0] = 1'b1;
    chk("abort_busy", 0, obusy[0], 0);
    chk("abort_err", 0, oerr[0], 0);
    chk("abort_vec", 0, ovec[0], 0);
    run(0, 0, 1);
    chk("after_abort_pass", 0, opass[0], 1);

    // start held through the run, then restarted from DONE
    run(0, 1, 505);
    chk("held_busy_cycles", 0, busy_cnt[0], 513);
    chk("held_err", 0, oerr[0], 256);
    fault[0] = 0;
    busy_cnt[0] = 0;
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    chk("restart_vec", 0, ovec[0], 0);
    chk("restart_err", 0, oerr[0], 0);
    wait_done(0);
    chk("restart_busy_cycles", 0, busy_cnt[0], 513);
    chk("restart_pass", 0, opass[0], 1);

    // LFSR mode, four vectors
    fault[1] = 0;
    busy_cnt[1] = 0;
    start[1] = 1'b1;
    cyc(1);
    start[1] = 1'b0;
    chk("lfsr_v0", 1, ovec[1], 9'h0A5);
    wait_done(1);
    chk("lfsr_busy_cycles", 1, busy_cnt[1], 5);
    chk("lfsr_pass", 1, opass[1], 1);

    // randomized runs
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(0, 2);
      f = $urandom_range(0, 3);
      if (f == 3)
        for (int i = 0; i < 512; i++)
          badmask[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      cyc($urandom_range(0, 5));
      plen = (k == 1) ? $urandom_range(1, 3) : $urandom_range(1, 20);
      run(k, f, plen);
      chk("rand_busy_cycles", k, busy_cnt[k], ncfg[k] + 1);
    end

    cyc(2);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
